// File: rtl/count_zeros_pkg.sv
// Shared constants and helpers for the count_zeros block: default width, count-width derivation
// and a reusable zero-bit counting function.
package count_zeros_pkg;

  localparam int unsigned DefaultWidth = 8;
  // Widest word count_zero_bits accepts; narrower words are zero-extended by the caller.
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Only the low `width` bits are examined, so zero-extension padding is never counted.
  function automatic int unsigned count_zero_bits(input logic [MaxWidth-1:0] word,
                                                  input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < width && !word[i]) begin
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/count_zeros_core.sv
// Combinational zero counters; the leading/trailing-zero outputs exist only when
// COUNT_ZEROS_LZTZ_EN is defined.
module count_zeros_core
  import count_zeros_pkg::*;
#(
  parameter int unsigned  WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] zeros
`ifdef COUNT_ZEROS_LZTZ_EN
  ,
  output logic [CNT_W-1:0] lz,
  output logic [CNT_W-1:0] tz
`endif
);

  assign zeros = CNT_W'(count_zero_bits(MaxWidth'(data), WIDTH));

`ifdef COUNT_ZEROS_LZTZ_EN
  logic lz_run;
  logic tz_run;

  // Each run flag drops at the first 1 seen, freezing the count.
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (lz_run && !data[i]) begin
        lz = lz + CNT_W'(1);
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  always_comb begin
    tz     = '0;
    tz_run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (tz_run && !data[i]) begin
        tz = tz + CNT_W'(1);
      end else begin
        tz_run = 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/count_zeros.sv
// Registered zero-bit counter with one-cycle latency. Defining COUNT_ZEROS_LZTZ_EN adds
// registered leading/trailing-zero counts sharing out_valid.
module count_zeros
  import count_zeros_pkg::*;
#(
  parameter int unsigned  WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic [CNT_W-1:0] count
`ifdef COUNT_ZEROS_LZTZ_EN
  ,
  output logic [CNT_W-1:0] lz_count,
  output logic [CNT_W-1:0] tz_count
`endif
);

  logic [CNT_W-1:0] zeros;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q;

`ifdef COUNT_ZEROS_LZTZ_EN
  logic [CNT_W-1:0] lz;
  logic [CNT_W-1:0] tz;
  logic [CNT_W-1:0] lz_q;
  logic [CNT_W-1:0] tz_q;

  count_zeros_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data  (data),
    .zeros (zeros),
    .lz    (lz),
    .tz    (tz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_q <= '0;
      tz_q <= '0;
    end else if (in_valid) begin
      lz_q <= lz;
      tz_q <= tz;
    end
  end

  assign lz_count = lz_q;
  assign tz_count = tz_q;
`else
  count_zeros_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data  (data),
    .zeros (zeros)
  );
`endif

  // Results only load on accepted words, so data is ignored while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        count_q <= zeros;
      end
    end
  end

  assign count     = count_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_count_zeros.sv
// Scoreboard bench for count_zeros: stimulus pushes hand-computed results, a monitor pops and
// compares on every out_valid. Leading/trailing checks follow COUNT_ZEROS_LZTZ_EN.
module tb_count_zeros;

  typedef struct {
    int c;
    int lz;
    int tz;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] data;
  logic       out_valid;
  logic [3:0] count;
`ifdef COUNT_ZEROS_LZTZ_EN
  logic [3:0] lz_count;
  logic [3:0] tz_count;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_fail;
  int   hold_cnt;

  count_zeros #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data      (data),
    .out_valid (out_valid),
    .count     (count)
`ifdef COUNT_ZEROS_LZTZ_EN
    ,
    .lz_count  (lz_count),
    .tz_count  (tz_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp = n_cmp + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d, input int c, input int lz, input int tz);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    data     = d;
    e.c  = c;
    e.lz = lz;
    e.tz = tz;
    sb.push_back(e);
  endtask

  task automatic idle_check(input string name);
    check({name, " out_valid"}, int'(out_valid), 0);
    check({name, " count"}, int'(count), hold_cnt);
  endtask

  // Monitor: outputs are registered, so sampling on the falling edge is stable.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected out_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("count", int'(count), mon_e.c);
`ifdef COUNT_ZEROS_LZTZ_EN
          check("lz_count", int'(lz_count), mon_e.lz);
          check("tz_count", int'(tz_count), mon_e.tz);
`endif
        end
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    hold_cnt = 0;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    data     = 8'h00;
    #1 rst_n = 1'b0;

    // Reset held with live traffic: nothing may come out.
    repeat (4) begin
      @(negedge clk);
      data = 8'($urandom);
      check("reset out_valid", int'(out_valid), 0);
      check("reset count", int'(count), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    send(8'h00, 8, 8, 8);
    send(8'hE6, 3, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    hold_cnt = 3;
    @(negedge clk);
    idle_check("after pulse");

    send(8'hFF, 0, 0, 0);
    send(8'h01, 7, 7, 0);
    send(8'h80, 7, 0, 7);
    send(8'h0F, 4, 4, 0);
    send(8'hFE, 1, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    hold_cnt = 1;

    repeat (10) begin
      @(negedge clk);
      data = 8'($urandom);
      idle_check("idle");
    end

    // Asynchronous reset in the middle of a stream; the in-flight word is discarded.
    send(8'h01, 7, 7, 0);
    send(8'h80, 7, 0, 7);
    @(negedge clk);
    data = 8'h0F;
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset count", int'(count), 0);
    @(negedge clk);
    check("reset hold out_valid", int'(out_valid), 0);
    check("reset hold count", int'(count), 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    send(8'h3C, 4, 2, 2);
    @(negedge clk);
    in_valid = 1'b0;

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk);
    end
    check("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
